// File: rtl/bh_prg_loader_pkg.sv
// Shared constants for the brainhack program loader: opcodes, error codes,
// source characters, terminators and loader FSM states.
package bh_prg_loader_pkg;

  localparam int unsigned OPCODE_W      = 3;
  localparam int unsigned ERR_W         = 2;
  localparam int unsigned DEF_ADDR_W    = 10;
  localparam int unsigned DEF_INSTR_W   = 3;
  localparam int unsigned DEF_DEPTH_W   = 4;

  localparam logic [OPCODE_W-1:0] OP_INC_TP   = 3'b000;
  localparam logic [OPCODE_W-1:0] OP_DEC_TP   = 3'b001;
  localparam logic [OPCODE_W-1:0] OP_INC_DATA = 3'b010;
  localparam logic [OPCODE_W-1:0] OP_DEC_DATA = 3'b011;
  localparam logic [OPCODE_W-1:0] OP_OUT      = 3'b100;
  localparam logic [OPCODE_W-1:0] OP_IN       = 3'b101;
  localparam logic [OPCODE_W-1:0] OP_LOOP_BEG = 3'b110;
  localparam logic [OPCODE_W-1:0] OP_LOOP_END = 3'b111;

  localparam logic [7:0] CH_INC_TP   = 8'h3E; // '>'
  localparam logic [7:0] CH_DEC_TP   = 8'h3C; // '<'
  localparam logic [7:0] CH_INC_DATA = 8'h2B; // '+'
  localparam logic [7:0] CH_DEC_DATA = 8'h2D; // '-'
  localparam logic [7:0] CH_OUT      = 8'h2E; // '.'
  localparam logic [7:0] CH_IN       = 8'h2C; // ','
  localparam logic [7:0] CH_LOOP_BEG = 8'h5B; // '['
  localparam logic [7:0] CH_LOOP_END = 8'h5D; // ']'
  localparam logic [7:0] TERM_NUL    = 8'h00;
  localparam logic [7:0] TERM_BANG   = 8'h21; // '!'

  localparam logic [ERR_W-1:0] ERR_NONE      = 2'b00;
  localparam logic [ERR_W-1:0] ERR_UNMATCHED = 2'b01;
  localparam logic [ERR_W-1:0] ERR_UNCLOSED  = 2'b10;
  localparam logic [ERR_W-1:0] ERR_CAPACITY  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

endpackage

// File: rtl/bh_char_decoder.sv
// Combinational source-byte classifier: command flag, terminator flag and
// the instruction opcode for the eight brainfuck command characters.
module bh_char_decoder
  import bh_prg_loader_pkg::*;
(
  input  logic [7:0]          i_byte,
  output logic                o_is_cmd,
  output logic                o_is_term,
  output logic [OPCODE_W-1:0] o_opcode
);

  always_comb begin
    o_is_cmd  = 1'b1;
    o_is_term = 1'b0;
    o_opcode  = OP_INC_TP;
    case (i_byte)
      CH_INC_TP:   o_opcode = OP_INC_TP;
      CH_DEC_TP:   o_opcode = OP_DEC_TP;
      CH_INC_DATA: o_opcode = OP_INC_DATA;
      CH_DEC_DATA: o_opcode = OP_DEC_DATA;
      CH_OUT:      o_opcode = OP_OUT;
      CH_IN:       o_opcode = OP_IN;
      CH_LOOP_BEG: o_opcode = OP_LOOP_BEG;
      CH_LOOP_END: o_opcode = OP_LOOP_END;
      TERM_NUL, TERM_BANG: begin
        o_is_cmd  = 1'b0;
        o_is_term = 1'b1;
      end
      default:     o_is_cmd = 1'b0;
    endcase
  end

endmodule

// File: rtl/bh_prg_loader.sv
// Program loader: filters and encodes a brainfuck source byte stream into
// program memory, checking bracket balance and capacity while holding the core.
module bh_prg_loader
  import bh_prg_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_W,
  parameter int unsigned INSTR_WIDTH = DEF_INSTR_W,
  parameter int unsigned DEPTH_WIDTH = DEF_DEPTH_W
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic                   i_rx_valid,
  input  logic [7:0]             i_rx_data,
  output logic                   o_rx_ready,
  output logic                   o_prgmem_in,
  output logic [ADDR_WIDTH-1:0]  o_prgmem_addr,
  output logic [INSTR_WIDTH-1:0] o_prgmem_data,
  output logic [ADDR_WIDTH:0]    o_prg_length,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_error,
  output logic [ERR_W-1:0]       o_error_code,
  output logic                   o_cpu_hold
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0]       PTR_FULL  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [DEPTH_WIDTH-1:0] DEPTH_MAX = '1;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [DEPTH_WIDTH-1:0]  depth_q, depth_d;
  logic [ERR_W-1:0]        err_q, err_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [INSTR_WIDTH-1:0]  wdata_q, wdata_d;
  logic                    hold_q, hold_d;
  logic                    ready_q, busy_q, done_q, error_q;

  logic                    is_cmd, is_term;
  logic [OPCODE_W-1:0]     opcode;

  bh_char_decoder u_dec (
    .i_byte    (i_rx_data),
    .o_is_cmd  (is_cmd),
    .o_is_term (is_term),
    .o_opcode  (opcode)
  );

  // Next-state: error checks are evaluated before any write is scheduled.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    depth_d = depth_q;
    err_d   = err_q;
    wr_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          depth_d = '0;
          err_d   = ERR_NONE;
          hold_d  = 1'b1;
        end
      end
      ST_LOAD: begin
        if (i_rx_valid) begin
          if (is_term) begin
            if (depth_q == '0) begin
              state_d = ST_DONE;
              hold_d  = 1'b0;
            end else begin
              state_d = ST_ERROR;
              err_d   = ERR_UNCLOSED;
            end
          end else if (is_cmd) begin
            if (opcode == OP_LOOP_END && depth_q == '0) begin
              state_d = ST_ERROR;
              err_d   = ERR_UNMATCHED;
            end else if ((opcode == OP_LOOP_BEG && depth_q == DEPTH_MAX) ||
                         ptr_q == PTR_FULL) begin
              state_d = ST_ERROR;
              err_d   = ERR_CAPACITY;
            end else begin
              wr_d    = 1'b1;
              waddr_d = ptr_q[ADDR_WIDTH-1:0];
              wdata_d = INSTR_WIDTH'(opcode);
              ptr_d   = ptr_q + PTR_W'(1);
              if (opcode == OP_LOOP_BEG) begin
                depth_d = depth_q + DEPTH_WIDTH'(1);
              end else if (opcode == OP_LOOP_END) begin
                depth_d = depth_q - DEPTH_WIDTH'(1);
              end
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      depth_q <= '0;
      err_q   <= ERR_NONE;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      ready_q <= (state_d == ST_LOAD);
      busy_q  <= (state_d == ST_LOAD);
      done_q  <= (state_d == ST_DONE);
      error_q <= (state_d == ST_ERROR);
    end
  end

  assign o_rx_ready    = ready_q;
  assign o_prgmem_in   = wr_q;
  assign o_prgmem_addr = waddr_q;
  assign o_prgmem_data = wdata_q;
  assign o_prg_length  = ptr_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_error       = error_q;
  assign o_error_code  = err_q;
  assign o_cpu_hold    = hold_q;

endmodule

// File: tb/tb_bh_prg_loader.sv
// Bench for bh_prg_loader: table vectors, hand-timed sequences and random
// streams checked against a string-level reference model.
module tb_bh_prg_loader;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 2;

  typedef logic [7:0] u8_t;

  typedef struct {
    string body;
    int    term;   // terminator byte, or -1 for none
    string ops;    // expected opcodes as decimal digits, in address order
    bit    done;
    int    code;
  } vec_t;

  logic          i_clock = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_start = 1'b0;
  logic          i_rx_valid = 1'b0;
  logic [7:0]    i_rx_data = 8'h00;
  logic          o_rx_ready;
  logic          o_prgmem_in;
  logic [AW-1:0] o_prgmem_addr;
  logic [2:0]    o_prgmem_data;
  logic [AW:0]   o_prg_length;
  logic          o_busy, o_done, o_error, o_cpu_hold;
  logic [1:0]    o_error_code;

  int n_tests = 0;
  int n_fail  = 0;
  logic [AW+2:0] cap[$];

  bh_prg_loader #(.ADDR_WIDTH(AW), .INSTR_WIDTH(3), .DEPTH_WIDTH(DW)) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_rx_valid   (i_rx_valid),
    .i_rx_data    (i_rx_data),
    .o_rx_ready   (o_rx_ready),
    .o_prgmem_in  (o_prgmem_in),
    .o_prgmem_addr(o_prgmem_addr),
    .o_prgmem_data(o_prgmem_data),
    .o_prg_length (o_prg_length),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_error_code (o_error_code),
    .o_cpu_hold   (o_cpu_hold)
  );

  always #5 i_clock = ~i_clock;

  always @(negedge i_clock)
    if (o_prgmem_in === 1'b1) cap.push_back({o_prgmem_addr, o_prgmem_data});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk the source as text, collecting the program words.
  function automatic void model(input u8_t src[$], output int ops[$],
                                output bit done, output int code);
    string cmds = "><+-.,[]";
    int depth = 0;
    int op;
    ops.delete();
    done = 1'b0;
    code = -1;
    foreach (src[k]) begin
      if (src[k] == 8'h00 || src[k] == 8'h21) begin
        if (depth == 0) begin done = 1'b1; code = 0; end
        else code = 2;
        return;
      end
      op = -1;
      for (int c = 0; c < 8; c++) if (u8_t'(cmds.getc(c)) == src[k]) op = c;
      if (op >= 0) begin
        if (op == 7 && depth == 0) begin code = 1; return; end
        if ((op == 6 && depth == (1 << DW) - 1) || ops.size() == (1 << AW)) begin
          code = 3;
          return;
        end
        ops.push_back(op);
        if (op == 6) depth++;
        if (op == 7) depth--;
      end
    end
  endfunction

  task automatic run(input u8_t src[$]);
    cap.delete();
    @(negedge i_clock); i_start = 1'b1;
    @(negedge i_clock); i_start = 1'b0;
    foreach (src[k]) begin
      i_rx_valid = 1'b1;
      i_rx_data  = src[k];
      @(negedge i_clock);
    end
    i_rx_valid = 1'b0;
    repeat (2) @(negedge i_clock);
  endtask

  task automatic check_load(input string tag, input int ops[$], input bit done, input int code);
    chk($sformatf("%s nwrites", tag), cap.size(), ops.size());
    for (int i = 0; i < ops.size() && i < cap.size(); i++) begin
      chk($sformatf("%s wr%0d addr", tag, i), 32'(cap[i][AW+2:3]), i);
      chk($sformatf("%s wr%0d data", tag, i), 32'(cap[i][2:0]), ops[i]);
    end
    chk($sformatf("%s done", tag), o_done, done);
    chk($sformatf("%s error", tag), o_error, !done);
    chk($sformatf("%s code", tag), o_error_code, done ? 0 : code);
    chk($sformatf("%s length", tag), o_prg_length, ops.size());
    chk($sformatf("%s hold", tag), o_cpu_hold, !done);
    chk($sformatf("%s busy", tag), o_busy, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " ready"}, o_rx_ready, 0);
    chk({tag, " wr"}, o_prgmem_in, 0);
    chk({tag, " addr"}, o_prgmem_addr, 0);
    chk({tag, " data"}, o_prgmem_data, 0);
    chk({tag, " length"}, o_prg_length, 0);
    chk({tag, " busy"}, o_busy, 0);
    chk({tag, " done"}, o_done, 0);
    chk({tag, " error"}, o_error, 0);
    chk({tag, " code"}, o_error_code, 0);
    chk({tag, " hold"}, o_cpu_hold, 1);
  endtask

  initial begin
    vec_t vecs[8];
    u8_t  src[$];
    int   ops[$];
    int   mcode;
    bit   mdone;
    string rpool;

    vecs[0] = '{"+[->+<]",   33, "2630217",  1'b1, 0};
    vecs[1] = '{"a+ b\n-",    0, "23",       1'b1, 0};
    vecs[2] = '{"+]",        -1, "2",        1'b0, 1};
    vecs[3] = '{"[[+]",      33, "6627",     1'b0, 2};
    vecs[4] = '{"+++++++++", 33, "22222222", 1'b0, 3};
    vecs[5] = '{"[[[[",      33, "666",      1'b0, 3};
    vecs[6] = '{"",          33, "",         1'b1, 0};
    vecs[7] = '{"++++++++",  33, "22222222", 1'b1, 0};

    repeat (2) @(negedge i_clock);
    check_reset_vals("reset");
    i_reset = 1'b0;

    foreach (vecs[v]) begin
      src.delete();
      ops.delete();
      for (int i = 0; i < vecs[v].body.len(); i++) src.push_back(u8_t'(vecs[v].body.getc(i)));
      if (vecs[v].term >= 0) src.push_back(u8_t'(vecs[v].term));
      for (int i = 0; i < vecs[v].ops.len(); i++) ops.push_back(int'(vecs[v].ops.getc(i)) - 48);
      run(src);
      check_load($sformatf("vec%0d", v), ops, vecs[v].done, vecs[v].code);
    end

    // Cycle-exact write timing, back-to-back writes, i_start ignored in LOAD.
    cap.delete();
    @(negedge i_clock); i_start = 1'b1;
    @(negedge i_clock); i_start = 1'b0;
    chk("seq ready", o_rx_ready, 1);
    chk("seq busy", o_busy, 1);
    chk("seq hold", o_cpu_hold, 1);
    chk("seq cleared len", o_prg_length, 0);
    chk("seq cleared done", o_done, 0);
    i_rx_valid = 1'b1; i_rx_data = 8'h2B;
    @(negedge i_clock);
    chk("seq wr0 strobe", o_prgmem_in, 1);
    chk("seq wr0 addr", o_prgmem_addr, 0);
    chk("seq wr0 data", o_prgmem_data, 3'b010);
    chk("seq len1", o_prg_length, 1);
    i_rx_data = 8'h2D; i_start = 1'b1;
    @(negedge i_clock);
    chk("seq wr1 strobe", o_prgmem_in, 1);
    chk("seq wr1 addr", o_prgmem_addr, 1);
    chk("seq wr1 data", o_prgmem_data, 3'b011);
    chk("seq start ignored", o_prg_length, 2);
    i_start = 1'b0; i_rx_data = 8'h21;
    @(negedge i_clock);
    i_rx_valid = 1'b0;
    chk("seq term no write", o_prgmem_in, 0);
    chk("seq done", o_done, 1);
    chk("seq ready low", o_rx_ready, 0);
    chk("seq hold released", o_cpu_hold, 0);
    chk("seq final len", o_prg_length, 2);

    // Asynchronous reset in the middle of a load with a write pending.
    @(negedge i_clock); i_start = 1'b1;
    @(negedge i_clock); i_start = 1'b0;
    i_rx_valid = 1'b1; i_rx_data = 8'h2B;
    @(negedge i_clock);
    chk("rst pre strobe", o_prgmem_in, 1);
    #2 i_reset = 1'b1;
    #1 check_reset_vals("rst async");
    @(negedge i_clock);
    i_reset = 1'b0;
    @(negedge i_clock);
    chk("rst idle ignores rx", o_prg_length, 0);
    chk("rst idle no write", o_prgmem_in, 0);
    i_rx_valid = 1'b0;
    src = '{8'h2B, 8'h2D, 8'h21};
    ops = '{2, 3};
    run(src);
    check_load("rst reload", ops, 1'b1, 0);

    // Random streams against the reference model.
    rpool = "><+-.,[][]]ab \n#0";
    for (int t = 0; t < 40; t++) begin
      int n;
      int r;
      src.delete();
      n = $urandom_range(0, 14);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, rpool.len() + 1);
        if (r < rpool.len()) src.push_back(u8_t'(rpool.getc(r)));
        else if (r == rpool.len()) src.push_back(8'hFF);
        else src.push_back(($urandom_range(0, 3) == 0) ? 8'h00 : 8'h41);
      end
      src.push_back(8'h21);
      model(src, ops, mdone, mcode);
      run(src);
      check_load($sformatf("rand%0d", t), ops, mdone, mcode);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
